// File: rtl/mem_arbiter.sv
// Single-port RAM arbiter between an instruction fetch and a data requester.
// Define MEM_ARBITER_LLSC_EN to add a link register for LL/SC support.
module mem_arbiter (
    input  logic        CLK,
    input  logic        nRST,
    input  logic        iREN,
    input  logic [31:0] iaddr,
    output logic [31:0] iload,
    output logic        ihit,
    input  logic        dREN,
    input  logic        dWEN,
    input  logic        datomic,
    input  logic [31:0] daddr,
    input  logic [31:0] dstore,
    output logic [31:0] dload,
    output logic        dhit,
    output logic        ramREN,
    output logic        ramWEN,
    output logic [31:0] ramaddr,
    output logic [31:0] ramstore,
    input  logic [31:0] ramload,
    input  logic [1:0]  ramstate
);

    typedef enum logic [1:0] {IDLE, DREQ, IREQ} state_t;
    localparam logic [1:0] RAM_ACCESS = 2'd2;

    state_t state_q, state_d;
    logic   last_d_q, last_d_d;
    logic   d_pend;
    logic   sc_fail;

`ifdef MEM_ARBITER_LLSC_EN
    logic        link_valid_q, link_valid_d;
    logic [31:0] link_addr_q, link_addr_d;
    logic        ll_req, sc_req;

    assign ll_req  = dREN & ~dWEN & datomic;
    assign sc_req  = dWEN & datomic;
    assign sc_fail = sc_req & ~(link_valid_q && (daddr == link_addr_q));
`else
    logic unused_datomic;

    assign unused_datomic = datomic;
    assign sc_fail        = 1'b0;
`endif

    assign d_pend = dREN | dWEN;

    always_comb begin
        // NOTE: every output and next-state value gets a default first so no path infers a latch.
        state_d  = state_q;
        last_d_d = last_d_q;
        iload    = '0;
        ihit     = 1'b0;
        dload    = '0;
        dhit     = 1'b0;
        ramREN   = 1'b0;
        ramWEN   = 1'b0;
        ramaddr  = '0;
        ramstore = '0;
`ifdef MEM_ARBITER_LLSC_EN
        link_valid_d = link_valid_q;
        link_addr_d  = link_addr_q;
`endif
        unique case (state_q)
            IDLE: begin
                if (d_pend && iREN) state_d = last_d_q ? IREQ : DREQ;
                else if (d_pend)    state_d = DREQ;
                else if (iREN)      state_d = IREQ;
            end
            DREQ: begin
                ramaddr = daddr;
                if (!d_pend) begin
                    state_d = IDLE;
                end else if (sc_fail) begin
                    // A store-conditional that has lost its link completes at once without touching RAM.
                    dhit     = 1'b1;
                    last_d_d = 1'b1;
                    state_d  = IDLE;
                end else begin
                    ramstore = dstore;
                    ramWEN   = dWEN;
                    ramREN   = dREN & ~dWEN;
                    if (ramstate == RAM_ACCESS) begin
                        dhit     = 1'b1;
                        dload    = dWEN ? '0 : ramload;
                        last_d_d = 1'b1;
                        state_d  = IDLE;
`ifdef MEM_ARBITER_LLSC_EN
                        if (sc_req) dload = 32'd1;
                        if (ll_req) begin
                            link_valid_d = 1'b1;
                            link_addr_d  = daddr;
                        end else if (dWEN && (daddr == link_addr_q)) begin
                            link_valid_d = 1'b0;
                        end
`endif
                    end
                end
            end
            IREQ: begin
                ramaddr = iaddr;
                ramREN  = iREN;
                if (!iREN) begin
                    state_d = IDLE;
                end else if (ramstate == RAM_ACCESS) begin
                    ihit     = 1'b1;
                    iload    = ramload;
                    last_d_d = 1'b0;
                    state_d  = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q  <= IDLE;
            last_d_q <= 1'b0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so all flops update together.
            state_q  <= state_d;
            last_d_q <= last_d_d;
        end
    end

`ifdef MEM_ARBITER_LLSC_EN
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            link_valid_q <= 1'b0;
            link_addr_q  <= '0;
        end else begin
            link_valid_q <= link_valid_d;
            link_addr_q  <= link_addr_d;
        end
    end
`endif

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed self-checking bench for mem_arbiter; LL/SC vectors run when
// MEM_ARBITER_LLSC_EN is defined, otherwise SC is checked as a plain store.
module tb_mem_arbiter;

    logic        CLK = 1'b0;
    logic        nRST;
    logic        iREN, dREN, dWEN, datomic;
    logic [31:0] iaddr, daddr, dstore, ramload;
    logic [1:0]  ramstate;
    logic [31:0] iload, dload, ramaddr, ramstore;
    logic        ihit, dhit, ramREN, ramWEN;

    int n_vec = 0;
    int n_bad = 0;

    localparam logic [1:0] FREE = 2'd0, BUSY = 2'd1, ACCESS = 2'd2, ERROR = 2'd3;

    mem_arbiter dut (
        .CLK(CLK), .nRST(nRST),
        .iREN(iREN), .iaddr(iaddr), .iload(iload), .ihit(ihit),
        .dREN(dREN), .dWEN(dWEN), .datomic(datomic),
        .daddr(daddr), .dstore(dstore), .dload(dload), .dhit(dhit),
        .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
        .ramload(ramload), .ramstate(ramstate)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        nRST = 1'b0; iREN = 1'b1; dREN = 1'b1; dWEN = 1'b0; datomic = 1'b0;
        iaddr = 32'h40; daddr = 32'h80; dstore = 32'h0;
        ramload = 32'hFFFF_FFFF; ramstate = ACCESS;
        repeat (2) tick();
        check("rst_ramREN", 32'(ramREN), 0);
        check("rst_ramaddr", ramaddr, 0);
        check("rst_hits", {30'd0, ihit, dhit}, 0);
        check("rst_loads", iload | dload, 0);

        iREN = 1'b0; dREN = 1'b0; nRST = 1'b1;
        tick();
        check("idle_ramaddr", ramaddr, 0);

        // Single instruction fetch hitting in its first cycle
        iREN = 1'b1; iaddr = 32'h40; ramload = 32'h8C22_0004;
        #1;
        check("ifetch_idle_ihit", 32'(ihit), 0);
        tick();
        check("ifetch_ihit", 32'(ihit), 1);
        check("ifetch_iload", iload, 32'h8C22_0004);
        check("ifetch_ramaddr", ramaddr, 32'h40);
        check("ifetch_ramREN", 32'(ramREN), 1);
        check("ifetch_dhit", 32'(dhit), 0);
        tick();
        iREN = 1'b0;
        #1;
        check("ifetch_after_ihit", 32'(ihit), 0);
        check("ifetch_after_iload", iload, 0);

        // Both pending with lastD=0: data first, then fetch
        iREN = 1'b1; dREN = 1'b1; daddr = 32'h80; ramload = 32'h1111_2222;
        tick();
        check("both_d_dhit", 32'(dhit), 1);
        check("both_d_dload", dload, 32'h1111_2222);
        check("both_d_ramaddr", ramaddr, 32'h80);
        check("both_d_ihit", 32'(ihit), 0);
        tick();
        check("both_idle_ramREN", 32'(ramREN), 0);
        check("both_idle_dload", dload, 0);
        tick();
        check("both_i_ihit", 32'(ihit), 1);
        check("both_i_dhit", 32'(dhit), 0);
        check("both_i_ramaddr", ramaddr, 32'h40);
        tick();
        iREN = 1'b0; dREN = 1'b0;

        // Store with three BUSY cycles before ACCESS
        dWEN = 1'b1; daddr = 32'h100; dstore = 32'hDEAD_BEEF; ramstate = BUSY; ramload = 32'h0;
        tick();
        for (int i = 0; i < 4; i++) begin
            if (i == 3) begin
                ramstate = ACCESS;
                #1;
            end
            check($sformatf("store_ramWEN_%0d", i), 32'(ramWEN), 1);
            check($sformatf("store_dhit_%0d", i), 32'(dhit), (i == 3) ? 1 : 0);
            if (i < 3) tick();
        end
        check("store_ramstore", ramstore, 32'hDEAD_BEEF);
        check("store_ramaddr", ramaddr, 32'h100);
        check("store_ramREN", 32'(ramREN), 0);
        tick();
        dWEN = 1'b0;
        #1;
        check("store_idle_ramWEN", 32'(ramWEN), 0);

        // dREN and dWEN together behave as a write
        dREN = 1'b1; dWEN = 1'b1; daddr = 32'h104; dstore = 32'h1234_5678;
        tick();
        check("rw_ramREN", 32'(ramREN), 0);
        check("rw_ramWEN", 32'(ramWEN), 1);
        check("rw_dhit", 32'(dhit), 1);
        tick();
        dREN = 1'b0; dWEN = 1'b0;

        // ERROR holds the read asserted until ACCESS
        dREN = 1'b1; daddr = 32'h108; ramstate = ERROR; ramload = 32'hCAFE_F00D;
        tick();
        check("err_dhit_0", 32'(dhit), 0);
        check("err_ramREN_0", 32'(ramREN), 1);
        check("err_dload_0", dload, 0);
        tick();
        check("err_dhit_1", 32'(dhit), 0);
        check("err_ramaddr_1", ramaddr, 32'h108);
        ramstate = ACCESS;
        #1;
        check("err_dhit_2", 32'(dhit), 1);
        check("err_dload_2", dload, 32'hCAFE_F00D);
        tick();
        dREN = 1'b0;

        // Fetch withdrawn while granted: no hit, lastD stays 1
        iREN = 1'b1; iaddr = 32'h44; ramstate = BUSY;
        tick();
        check("wd_ramREN", 32'(ramREN), 1);
        iREN = 1'b0;
        #1;
        check("wd_ihit", 32'(ihit), 0);
        tick();
        check("wd_idle_ramaddr", ramaddr, 0);
        iREN = 1'b1; dREN = 1'b1; daddr = 32'h10C; ramstate = ACCESS; ramload = 32'h5A5A_5A5A;
        tick();
        check("wd_grant_ihit", 32'(ihit), 1);
        check("wd_grant_dhit", 32'(dhit), 0);
        check("wd_grant_ramaddr", ramaddr, 32'h44);
        tick();
        iREN = 1'b0; dREN = 1'b0;

        // Reset asserted mid-access
        dREN = 1'b1; daddr = 32'h110; ramstate = BUSY;
        tick();
        check("rstmid_ramREN_pre", 32'(ramREN), 1);
        #2;
        nRST = 1'b0;
        #1;
        check("rstmid_ramREN", 32'(ramREN), 0);
        check("rstmid_ramaddr", ramaddr, 0);
        ramstate = ACCESS;
        #1;
        check("rstmid_dhit", 32'(dhit), 0);
        check("rstmid_dload", dload, 0);
        tick();
        dREN = 1'b0; nRST = 1'b1;
        #1;
        check("rstmid_after_ramaddr", ramaddr, 0);
        check("rstmid_after_dhit", 32'(dhit), 0);

`ifdef MEM_ARBITER_LLSC_EN
        // LL then SC succeeds; repeated SC fails without writing
        dREN = 1'b1; datomic = 1'b1; daddr = 32'h200; ramstate = ACCESS; ramload = 32'h0;
        tick();
        check("ll_dhit", 32'(dhit), 1);
        tick();
        dREN = 1'b0; dWEN = 1'b1; dstore = 32'h77;
        tick();
        check("sc_ok_ramWEN", 32'(ramWEN), 1);
        check("sc_ok_dhit", 32'(dhit), 1);
        check("sc_ok_dload", dload, 1);
        tick();
        ramstate = BUSY;
        tick();
        check("sc_again_ramWEN", 32'(ramWEN), 0);
        check("sc_again_dhit", 32'(dhit), 1);
        check("sc_again_dload", dload, 0);
        tick();
        dWEN = 1'b0;

        // LL, plain store to the same address, then SC fails
        dREN = 1'b1; ramstate = ACCESS;
        tick();
        check("ll2_dhit", 32'(dhit), 1);
        tick();
        dREN = 1'b0; datomic = 1'b0; dWEN = 1'b1;
        tick();
        check("sw_ramWEN", 32'(ramWEN), 1);
        check("sw_dhit", 32'(dhit), 1);
        tick();
        datomic = 1'b1;
        tick();
        check("sc_broken_ramWEN", 32'(ramWEN), 0);
        check("sc_broken_dhit", 32'(dhit), 1);
        check("sc_broken_dload", dload, 0);
        tick();
        dWEN = 1'b0; datomic = 1'b0;
`else
        // Without link support an SC is an ordinary store
        dWEN = 1'b1; datomic = 1'b1; daddr = 32'h200; dstore = 32'h77;
        ramstate = ACCESS; ramload = 32'h0;
        tick();
        check("sc_plain_ramWEN", 32'(ramWEN), 1);
        check("sc_plain_dhit", 32'(dhit), 1);
        check("sc_plain_dload", dload, 0);
        tick();
        dWEN = 1'b0; datomic = 1'b0;
`endif

        tick();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
